// File: rtl/cfg_stream_reader_if.sv
// Descriptor, memory-read and output-stream signals of cfg_stream_reader.
// The master modport is the reader itself. The slave modport is the surrounding environment.
interface cfg_stream_reader_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16,
    parameter int LWIDTH = 12
);
    logic              cfg_valid;
    logic              cfg_busy;
    logic [AWIDTH-1:0] cfg_base_addr;
    logic [LWIDTH-1:0] cfg_length;
    logic [AWIDTH-1:0] cfg_stride;

    logic              mem_rreq;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_rdata;

    logic              dout_valid;
    logic [DWIDTH-1:0] dout_data;
    logic              dout_last;
    logic              done;

    modport master (
        input  cfg_valid, cfg_base_addr, cfg_length, cfg_stride, mem_rdata,
        output cfg_busy, mem_rreq, mem_addr, dout_valid, dout_data, dout_last, done
    );

    modport slave (
        output cfg_valid, cfg_base_addr, cfg_length, cfg_stride, mem_rdata,
        input  cfg_busy, mem_rreq, mem_addr, dout_valid, dout_data, dout_last, done
    );
endinterface

// File: rtl/cfg_stream_reader.sv
// Takes one transfer descriptor (base, length, stride) and reads that many strided words from memory.
// The words are replayed as a valid/data stream with a two-cycle request-to-output latency.
module cfg_stream_reader #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16,
    parameter int LWIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cfg_stream_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] stride_q;
    logic [LWIDTH-1:0] len_q;
    logic [LWIDTH-1:0] cnt_q;

    logic              rd_pending;
    logic              rd_last;
    logic              dout_valid_q;
    logic              dout_last_q;
    logic [DWIDTH-1:0] dout_data_q;

    logic              busy;
    logic              accept;
    logic              rreq;
    logic              last_req;

    // The done cycle already counts as not busy, so a waiting descriptor is taken on the edge that ends it.
    assign busy     = (state == READ) || (state == DRAIN);
    assign accept   = bus.cfg_valid && !busy;
    assign rreq     = (state == READ);
    assign last_req = rreq && (cnt_q == (len_q - LWIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length descriptor still spends one busy cycle in DRAIN before signalling done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FINISH: begin
                if (accept) begin
                    state_next = (bus.cfg_length == '0) ? DRAIN : READ;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (last_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (dout_last_q || (len_q == '0)) begin
                    state_next = FINISH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            stride_q     <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            rd_pending   <= 1'b0;
            rd_last      <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_data_q  <= '0;
        end else begin
            if (accept) begin
                addr_q   <= bus.cfg_base_addr;
                stride_q <= bus.cfg_stride;
                len_q    <= bus.cfg_length;
                cnt_q    <= '0;
            end else if (rreq) begin
                addr_q <= addr_q + stride_q;
                cnt_q  <= cnt_q + LWIDTH'(1);
            end
            // Request tags follow the data: rd_* marks mem_rdata valid, dout_* marks the registered copy.
            rd_pending   <= rreq;
            rd_last      <= last_req;
            dout_valid_q <= rd_pending;
            dout_last_q  <= rd_last;
            if (rd_pending) begin
                dout_data_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.cfg_busy   = busy;
    assign bus.mem_rreq   = rreq;
    assign bus.mem_addr   = rreq ? addr_q : '0;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_data  = dout_data_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.done       = (state == FINISH);

endmodule

// File: tb/tb_cfg_stream_reader.sv
// Testbench for cfg_stream_reader. A cycle-indexed schedule, built from each accepted descriptor,
// is compared against the DUT every cycle. Table vectors and hand sequences cover the corner cases.
`timescale 1ns/1ps
module tb_cfg_stream_reader;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int LW   = 12;
    localparam int NCYC = 8192;

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        logic [AW-1:0] stride;
        int            exp_latency;
        int            exp_words;
        logic [AW-1:0] exp_last_addr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] last_data = '0;

    bit            e_rreq [NCYC];
    logic [AW-1:0] e_addr [NCYC];
    bit            e_dv   [NCYC];
    logic [DW-1:0] e_data [NCYC];
    bit            e_last [NCYC];
    bit            e_done [NCYC];
    bit            e_busy [NCYC];

    vec_t vecs [6];

    cfg_stream_reader_if #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) bus ();

    cfg_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(32'(a) * 3);
    endfunction

    // Memory answers one cycle after a request; in other cycles it returns junk.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_rreq ? mem_word(bus.mem_addr) : DW'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Accept at the edge that ends cycle c: requests in c+1.., words in c+3.., done after the last word.
    function automatic void schedule(input int c, input logic [AW-1:0] b,
                                     input logic [LW-1:0] l, input logic [AW-1:0] s);
        int n;
        int fin;
        logic [AW-1:0] a;
        n   = int'(l);
        fin = (n == 0) ? c + 2 : c + 3 + n;
        for (int i = 0; i < n; i++) begin
            a = AW'(int'(b) + i * int'(s));
            e_rreq[c + 1 + i] = 1'b1;
            e_addr[c + 1 + i] = a;
            e_dv[c + 3 + i]   = 1'b1;
            e_data[c + 3 + i] = mem_word(a);
            e_last[c + 3 + i] = (i == n - 1);
        end
        e_done[fin] = 1'b1;
        for (int t = c + 1; t < fin; t++) begin
            e_busy[t] = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        if (rst_n && bus.cfg_valid && !e_busy[cyc]) begin
            schedule(cyc, bus.cfg_base_addr, bus.cfg_length, bus.cfg_stride);
        end
        cyc = cyc + 1;
    end

    always @(negedge rst_n) begin
        for (int t = cyc; t < NCYC; t++) begin
            e_rreq[t] = 1'b0;
            e_addr[t] = '0;
            e_dv[t]   = 1'b0;
            e_data[t] = '0;
            e_last[t] = 1'b0;
            e_done[t] = 1'b0;
            e_busy[t] = 1'b0;
        end
        last_data = '0;
    end

    always @(negedge clk) begin
        chk("cfg_busy",   32'(bus.cfg_busy),   32'(e_busy[cyc]));
        chk("mem_rreq",   32'(bus.mem_rreq),   32'(e_rreq[cyc]));
        chk("mem_addr",   32'(bus.mem_addr),   e_rreq[cyc] ? 32'(e_addr[cyc]) : 32'd0);
        chk("dout_valid", 32'(bus.dout_valid), 32'(e_dv[cyc]));
        chk("dout_last",  32'(bus.dout_last),  32'(e_last[cyc]));
        chk("done",       32'(bus.done),       32'(e_done[cyc]));
        if (e_dv[cyc]) begin
            last_data = e_data[cyc];
        end
        chk("dout_data",  32'(bus.dout_data),  32'(last_data));
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input vec_t v, output int latency, output int words,
                                 output logic [AW-1:0] last_addr);
        int n;
        words     = 0;
        last_addr = '0;
        latency   = -1;
        @(negedge clk);
        bus.cfg_valid     = 1'b1;
        bus.cfg_base_addr = v.base;
        bus.cfg_length    = v.len;
        bus.cfg_stride    = v.stride;
        @(negedge clk);
        bus.cfg_valid     = 1'b0;
        bus.cfg_base_addr = AW'($urandom);
        bus.cfg_length    = LW'($urandom);
        bus.cfg_stride    = AW'($urandom);
        n = 1;
        while (n < 60) begin
            if (bus.mem_rreq) begin
                words++;
                last_addr = bus.mem_addr;
            end
            if (bus.done) begin
                latency = n;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic checkOutput(input vec_t v, input int latency, input int words,
                               input logic [AW-1:0] last_addr);
        chk("vec_done_latency", 32'(latency),   32'(v.exp_latency));
        chk("vec_word_count",   32'(words),     32'(v.exp_words));
        chk("vec_last_addr",    32'(last_addr), 32'(v.exp_last_addr));
    endtask

    initial begin
        int lat;
        int w;
        logic [AW-1:0] la;
        int n;
        int cnt;
        int seen;

        vecs[0] = '{16'h0010, 12'd4, 16'h0001, 7, 4, 16'h0013};
        vecs[1] = '{16'hFFFE, 12'd3, 16'h0002, 6, 3, 16'h0002};
        vecs[2] = '{16'h1234, 12'd0, 16'h0005, 2, 0, 16'h0000};
        vecs[3] = '{16'h0100, 12'd1, 16'h0007, 4, 1, 16'h0100};
        vecs[4] = '{16'h0040, 12'd5, 16'h0000, 8, 5, 16'h0040};
        vecs[5] = '{16'h8000, 12'd6, 16'h3000, 9, 6, 16'h7000};

        bus.cfg_valid     = 1'b0;
        bus.cfg_base_addr = '0;
        bus.cfg_length    = '0;
        bus.cfg_stride    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], lat, w, la);
            checkOutput(vecs[i], lat, w, la);
        end

        // Second descriptor is held valid for the whole first transfer.
        @(negedge clk);
        bus.cfg_valid     = 1'b1;
        bus.cfg_base_addr = 16'h0200;
        bus.cfg_length    = 12'd3;
        bus.cfg_stride    = 16'h0001;
        @(negedge clk);
        bus.cfg_base_addr = 16'h0300;
        bus.cfg_length    = 12'd2;
        bus.cfg_stride    = 16'h0004;
        n = 1;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'd6);
        chk("b2b_busy_in_done",  32'(bus.cfg_busy), 32'd0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("b2b_rreq_next",     32'(bus.mem_rreq), 32'd1);
        chk("b2b_addr_next",     32'(bus.mem_addr), 32'h0300);
        n = 1;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_latency", 32'(n), 32'd5);

        // Asynchronous reset after the third output word of an 8-word transfer.
        @(negedge clk);
        bus.cfg_valid     = 1'b1;
        bus.cfg_base_addr = 16'h0400;
        bus.cfg_length    = 12'd8;
        bus.cfg_stride    = 16'h0001;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        n   = 0;
        cnt = 0;
        while (cnt < 3 && n < 40) begin
            if (bus.dout_valid) begin
                cnt++;
            end
            if (cnt < 3) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rst_third_word_seen", 32'(cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cfg_busy",   32'(bus.cfg_busy),   32'd0);
        chk("rst_mem_rreq",   32'(bus.mem_rreq),   32'd0);
        chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
        chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_dout_data",  32'(bus.dout_data),  32'd0);
        chk("rst_dout_last",  32'(bus.dout_last),  32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.dout_valid || bus.done || bus.mem_rreq) begin
                seen++;
            end
        end
        chk("rst_no_residual", 32'(seen), 32'd0);

        $display("[TB] randomized descriptor traffic");
        repeat (600) begin
            @(negedge clk);
            bus.cfg_valid     = ($urandom_range(0, 3) == 0);
            bus.cfg_base_addr = AW'($urandom);
            bus.cfg_length    = LW'($urandom_range(0, 12));
            case ($urandom_range(0, 3))
                0:       bus.cfg_stride = '0;
                1:       bus.cfg_stride = 16'h0001;
                default: bus.cfg_stride = AW'($urandom);
            endcase
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
